// File: rtl/wb_uart_pkg.sv
// Shared UART definitions for the 8N1 receiver and transmitter: state encoding,
// default bit period and frame width.
package wb_uart_pkg;

  localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;
  localparam int          FRAME_BITS              = 8;

  // B0..B7 must stay consecutive: the receiver steps through them with +1.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_B0    = 4'd2,
    ST_B1    = 4'd3,
    ST_B2    = 4'd4,
    ST_B3    = 4'd5,
    ST_B4    = 4'd6,
    ST_B5    = 4'd7,
    ST_B6    = 4'd8,
    ST_B7    = 4'd9,
    ST_STOP  = 4'd10,
    ST_BREAK = 4'd11
  } uart_state_e;

endpackage

// File: rtl/wb_uart_rx_if.sv
// Receiver-to-consumer bundle: recovered byte, strobes, busy and FSM state for debug.
interface wb_uart_rx_if;
  import wb_uart_pkg::*;

  // wr and frame_err are single-cycle strobes with no ready: data holds between
  // strobes and the consumer must take it before the next frame completes.
  logic                  wr;
  logic [FRAME_BITS-1:0] data;
  logic                  frame_err;
  logic                  busy;
  uart_state_e           state;

  modport master (output wr, data, frame_err, busy, state);
  modport slave  (input  wr, data, frame_err, busy, state);

endinterface

// File: rtl/wb_uart_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high.
module wb_uart_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre and emits the byte as a
// one-cycle strobe, or a frame-error strobe when the stop bit is low.
module wb_uart_rx
  import wb_uart_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_uart_rx,
  output logic                  o_wr,
  output logic [FRAME_BITS-1:0] o_data,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam logic [23:0] HALF = CLOCKS_PER_BAUD >> 1;

  logic                  w_rx;
  logic                  w_strobe;
  uart_state_e           r_state, w_state_nx;
  logic [23:0]           r_cnt, w_cnt_nx;
  logic [FRAME_BITS-1:0] r_sr, w_sr_nx;
  logic [FRAME_BITS-1:0] r_data, w_data_nx;
  logic                  r_wr, w_wr_nx;
  logic                  r_ferr, w_ferr_nx;

  wb_uart_rx_if u_out ();

  wb_uart_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_uart_rx),
    .o_sync  (w_rx)
  );

  assign w_strobe = (r_cnt == 24'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 24'd0;
      r_sr    <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sr    <= w_sr_nx;
      r_data  <= w_data_nx;
      r_wr    <= w_wr_nx;
      r_ferr  <= w_ferr_nx;
    end
  end

  // The counter is forced to zero whenever IDLE or BREAK is entered, so a
  // non-zero count always means a timed state is in progress.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sr_nx    = r_sr;
    w_data_nx  = r_data;
    w_wr_nx    = 1'b0;
    w_ferr_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx) begin
          w_state_nx = ST_START;
          w_cnt_nx   = HALF - 24'd1;
        end
      end
      ST_BREAK: begin
        if (w_rx) w_state_nx = ST_IDLE;
      end
      default: begin
        if (!w_strobe) begin
          w_cnt_nx = r_cnt - 24'd1;
        end else begin
          w_cnt_nx = CLOCKS_PER_BAUD - 24'd1;
          case (r_state)
            ST_START: begin
              if (w_rx) begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = 24'd0;
              end else begin
                w_state_nx = ST_B0;
              end
            end
            ST_STOP: begin
              w_cnt_nx = 24'd0;
              if (w_rx) begin
                w_data_nx  = r_sr;
                w_wr_nx    = 1'b1;
                w_state_nx = ST_IDLE;
              end else begin
                w_ferr_nx  = 1'b1;
                w_state_nx = ST_BREAK;
              end
            end
            default: begin
              w_sr_nx    = {w_rx, r_sr[FRAME_BITS-1:1]};
              w_state_nx = (r_state == ST_B7) ? ST_STOP
                                              : uart_state_e'(r_state + 4'd1);
            end
          endcase
        end
      end
    endcase
  end

  assign u_out.wr        = r_wr;
  assign u_out.data      = r_data;
  assign u_out.frame_err = r_ferr;
  assign u_out.busy      = (r_state != ST_IDLE);
  assign u_out.state     = r_state;

  assign o_wr        = u_out.wr;
  assign o_data      = u_out.data;
  assign o_frame_err = u_out.frame_err;
  assign o_busy      = u_out.busy;

endmodule

// File: doc/wb_uart_rx.md
Name: wb_uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's 8N1 transmitter (wb_uart_tx).
- Samples the asynchronous serial line and recovers frames of 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Presents each recovered byte as a one-cycle write strobe with data; flags bad stop bits.
- Sits between the board RX pin and the same Wishbone-side logic that drives the transmitter.

Parameters:
- CLOCKS_PER_BAUD, 24'd868, clocks per bit period. Legal range 4 to 2^24-1. Must match the transmitter.

Ports:
- i_clk  input  1  system clock; every flop is on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_uart_rx  input  1  raw serial line; idles high; asynchronous to i_clk.
- o_wr  output  1  one-cycle pulse: o_data holds a valid new byte.
- o_data  output  8  last correctly received byte; holds value between strobes.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset, applied asynchronously:
  - Both synchronizer flops = 1. State = IDLE. Counter = 0. Shift register = 0.
  - o_wr = 0, o_data = 8'h00, o_frame_err = 0, o_busy = 0.
  - Reset mid-frame abandons the frame. No strobe is issued for it.
- Synchronizer: 2-flop synchronizer on i_uart_rx produces rx_s. All decisions use rx_s only.
- HALF = CLOCKS_PER_BAUD/2, integer division. Counter is 24 bits; strobe = (counter == 0).
- States: IDLE, START, B0..B7, STOP, BREAK.
- IDLE, rx_s == 0: go to START, load counter = HALF-1.
- Any non-IDLE state: counter != 0 decrements. At strobe, the state acts as listed below and reloads counter = CLOCKS_PER_BAUD-1.
- START at strobe:
  - rx_s == 0: go to B0.
  - rx_s == 1: glitch; return to IDLE. No output activity.
- Bn at strobe: shift register <= {rx_s, sr[7:1]}; go to B(n+1). B7 goes to STOP.
- STOP at strobe:
  - rx_s == 1: o_data <= sr, o_wr = 1 for exactly one cycle, go to IDLE.
  - rx_s == 0: o_frame_err = 1 for one cycle, o_data unchanged, go to BREAK.
- BREAK: stay until rx_s == 1, then go to IDLE. Held-low line (break) never re-triggers a start.
- o_wr and o_frame_err are never high in the same cycle.
- Latency, with E0 = first clock edge sampling i_uart_rx = 0 from idle:
  - Data bit n is sampled at edge E(HALF + 2 + (n+1)·CLOCKS_PER_BAUD).
  - Stop bit is sampled at E(HALF + 2 + 9·CLOCKS_PER_BAUD); o_wr is high in the cycle after that edge.
  - Default parameter: E8248.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. A start edge arriving half a bit later is accepted with no gap.
- Baud tolerance: sampling is at bit centre, so the block tolerates about ±4% accumulated clock mismatch.
- No backpressure: the consumer must take o_data within one frame time.
- Formal invariants:
  - counter < CLOCKS_PER_BAUD.
  - counter != 0 implies o_busy.
  - o_wr implies the previous state was STOP.

Decomposition:
- Shared package wb_uart_pkg holds:
  - state encoding enum (IDLE, START, B0..B7, STOP, BREAK), 4 bits;
  - default CLOCKS_PER_BAUD constant (24'd868);
  - frame width constant (8 data bits).
- The transmitter migrates to the same package.
- One natural sub-module: wb_uart_sync, the 2-flop synchronizer. It has async reset to 1 and is reusable for other async inputs.

Test Plan (CLOCKS_PER_BAUD = 16, HALF = 8, unless noted):
- Drive frame 8'hA5 at 16 clocks/bit from E0 -> o_wr pulses once after E154, o_data = 8'hA5, o_frame_err stays 0.
- Drive a 3-clock low glitch from idle -> state returns to IDLE after E10; no o_wr, no o_frame_err.
- Drive frame 8'h3C with stop bit low, then line low for 40 clocks, then high -> one o_frame_err pulse; o_data keeps its previous value; o_busy drops 2 clocks after the line rises; no extra frames.
- Drive frames 8'h00, 8'hFF, 8'h81 back-to-back with no idle gap -> three o_wr pulses exactly 160 clocks apart, with the correct data each time.
- Assert i_reset during B4 of frame 8'h55 -> all outputs are 0 immediately; no strobe; the next clean frame 8'h12 is received correctly.
- Loopback with wb_uart_tx at CLOCKS_PER_BAUD = 868 over 256 random bytes -> every byte is matched and no frame errors occur.
